pipe_flush_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges per-stage stall

---
 rtl/pipe_flush_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_flush_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: stall merge and exception/ERET redirect sequencer for the
// 5-stage pipeline, with saturating stall statistics and a sticky stall watchdog.
module pipe_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000E,
    parameter int          TIMEOUT    = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_type,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);

    localparam int RW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] target;
    logic        accept;
    logic [RW-1:0] run_len, run_len_nxt;

    // Next state and stall/flush decode; reset forces an idle pipeline view.
    always_comb begin
        state_nxt = state;
        stall     = 6'b000000;
        flush     = 1'b0;
        new_pc    = 32'h0;
        accept    = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    // A data access in flight must finish before MEM can redirect.
                    accept = excp_valid && !stallreq_mem;
                    if (accept) begin
                        stall     = 6'b111111;
                        state_nxt = stallreq_if ? PEND : FLUSH;
                    end else if (stallreq_mem) stall = 6'b011111;
                    else if (stallreq_ex)      stall = 6'b001111;
                    else if (stallreq_id)      stall = 6'b000111;
                    else if (stallreq_if)      stall = 6'b000011;
                end
                PEND: begin
                    // Freeze everything until the outstanding fetch returns.
                    stall = 6'b111111;
                    if (!stallreq_if) state_nxt = FLUSH;
                end
                FLUSH: begin
                    flush     = 1'b1;
                    new_pc    = target;
                    state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Consecutive stalled cycles in any state, saturating at the watchdog limit.
    always_comb begin
        run_len_nxt = '0;
        if (stall != 6'b000000)
            run_len_nxt = (run_len >= RUN_MAX) ? RUN_MAX : run_len + RW'(1);
    end

    // State register and redirect target latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            target <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept)
                target <= (excp_type == ERET_CODE) ? cp0_epc : EXC_VECTOR;
        end
    end

    // Stall statistics: RUN-only saturating counter, run length and sticky watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt     <= '0;
            run_len       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (state == RUN && stall != 6'b000000 && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            run_len <= run_len_nxt;
            if (run_len_nxt >= RUN_MAX)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl (TIMEOUT shortened to 8).
module tb_pipe_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_type, cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        stall_timeout;

    int total = 0;
    int bad   = 0;

    pipe_flush_ctrl #(.TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_type(excp_type), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excp_valid = 0; excp_type = 32'h0; cp0_epc = 32'h0;

        // 1: reset then idle
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        chk("rst_cnt", stall_cnt, 32'h0);
        chk("rst_tmo", 32'(stall_timeout), 32'h0);

        // 2: priority ex over if, then if alone
        tick();
        stallreq_if = 1; stallreq_ex = 1; #1;
        chk("prio_ex_if", 32'(stall), 32'h0F);
        tick();
        stallreq_ex = 0; #1;
        chk("prio_if", 32'(stall), 32'h03);
        stallreq_id = 1; #1;
        chk("prio_id_if", 32'(stall), 32'h07);
        stallreq_id = 0; #1;
        tick();
        stallreq_if = 0; #1;
        chk("prio_idle", 32'(stall), 32'h0);
        chk("cnt_2", stall_cnt, 32'd2);

        // 3: exception with fetch idle
        tick();
        excp_valid = 1; excp_type = 32'h8; #1;
        chk("exc_acc_stall", 32'(stall), 32'h3F);
        chk("exc_acc_flush", 32'(flush), 32'h0);
        tick();
        excp_valid = 0; #1;
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_newpc", new_pc, 32'hBFC00380);
        chk("exc_flush_stall", 32'(stall), 32'h0);
        tick();
        chk("exc_done_flush", 32'(flush), 32'h0);
        chk("exc_done_stall", 32'(stall), 32'h0);
        chk("exc_done_newpc", new_pc, 32'h0);
        chk("cnt_3", stall_cnt, 32'd3);

        // 4: ERET with fetch busy for 3 cycles (accept + 2 PEND), 1 PEND cycle after release
        excp_valid = 1; excp_type = 32'hE; cp0_epc = 32'hBFC01234; stallreq_if = 1; #1;
        chk("eret_acc_stall", 32'(stall), 32'h3F);
        tick();
        excp_valid = 0; stallreq_mem = 1; #1;
        chk("eret_pend1", 32'(stall), 32'h3F);
        chk("eret_pend1_flush", 32'(flush), 32'h0);
        tick();
        stallreq_mem = 0; #1;
        chk("eret_pend2", 32'(stall), 32'h3F);
        tick();
        stallreq_if = 0; #1;
        chk("eret_pend3", 32'(stall), 32'h3F);
        chk("eret_pend3_flush", 32'(flush), 32'h0);
        tick();
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_newpc", new_pc, 32'hBFC01234);
        chk("eret_flush_stall", 32'(stall), 32'h0);
        tick();
        chk("eret_done_flush", 32'(flush), 32'h0);
        chk("cnt_4", stall_cnt, 32'd4);

        // 5: exception blocked by mem stall, accepted once mem releases
        excp_valid = 1; excp_type = 32'h8; stallreq_mem = 1; #1;
        chk("memblk_stall", 32'(stall), 32'h1F);
        chk("memblk_flush", 32'(flush), 32'h0);
        tick();
        chk("memblk_noflush", 32'(flush), 32'h0);
        stallreq_mem = 0; #1;
        chk("memrel_acc", 32'(stall), 32'h3F);
        tick();
        excp_valid = 0; #1;
        chk("memrel_flush", 32'(flush), 32'h1);
        chk("memrel_newpc", new_pc, 32'hBFC00380);
        tick();
        chk("memrel_done", 32'(flush), 32'h0);
        chk("cnt_6", stall_cnt, 32'd6);

        // 6: watchdog with TIMEOUT=8
        stallreq_ex = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tmo_stall", 32'(stall), 32'h0F);
            if (i == 7) chk("tmo_before", 32'(stall_timeout), 32'h0);
            tick();
        end
        stallreq_ex = 0; #1;
        chk("tmo_set", 32'(stall_timeout), 32'h1);
        chk("cnt_14", stall_cnt, 32'd14);
        tick(); tick();
        chk("tmo_sticky", 32'(stall_timeout), 32'h1);
        chk("tmo_idle_stall", 32'(stall), 32'h0);

        // Reset while in PEND drops the redirect
        excp_valid = 1; excp_type = 32'h8; stallreq_if = 1;
        tick();
        excp_valid = 0; #1;
        chk("pend_stall", 32'(stall), 32'h3F);
        rst = 1;
        tick();
        rst = 0; stallreq_if = 0; #1;
        chk("rstpend_stall", 32'(stall), 32'h0);
        chk("rstpend_flush", 32'(flush), 32'h0);
        chk("rstpend_tmo", 32'(stall_timeout), 32'h0);
        chk("rstpend_cnt", stall_cnt, 32'h0);
        tick();
        chk("rstpend_noflush", 32'(flush), 32'h0);
        chk("rstpend_newpc", new_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
